// File: rtl/free_list_if.sv
// Rename/commit port bundle for the physical-register free list.
// master: rename + commit side driving requests; slave: the free list itself.
interface free_list_if #(
    parameter int FETCH_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int TAG_W        = 6
);
    logic [FETCH_WIDTH-1:0]        rename_valid;
    logic                          rename_ready;
    logic [FETCH_WIDTH*TAG_W-1:0]  alloc_tag;
    logic [COMMIT_WIDTH-1:0]       commit_valid;
    logic [COMMIT_WIDTH-1:0]       commit_alloc;
    logic [COMMIT_WIDTH*TAG_W-1:0] commit_free_tag;
    logic                          flush;
    logic [TAG_W:0]                free_count;

    modport master (
        output rename_valid, commit_valid, commit_alloc, commit_free_tag, flush,
        input  rename_ready, alloc_tag, free_count
    );

    modport slave (
        input  rename_valid, commit_valid, commit_alloc, commit_free_tag, flush,
        output rename_ready, alloc_tag, free_count
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags between rename
// (allocate, up to FETCH_WIDTH per cycle) and ROB commit (free, up to
// COMMIT_WIDTH per cycle). commit_head tracks the head as seen by retired
// instructions so a flush rewinds head in a single cycle.
// Optional: define FREE_LIST_ASSERT_EN for simulation-only sanity checks.
module free_list #(
    parameter int PHYS_REGS    = 64,
    parameter int ARCH_REGS    = 32,
    parameter int FETCH_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 4
) (
    input logic       clk_sys,
    input logic       rst_b,
    free_list_if.slave fl
);
    localparam int TAG_W = $clog2(PHYS_REGS);
    localparam logic [TAG_W:0] INIT_FREE = (TAG_W+1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [TAG_W:0] FW_CNT    = (TAG_W+1)'(FETCH_WIDTH);

    logic [TAG_W-1:0] mem_q [PHYS_REGS];
    logic [TAG_W-1:0] mem_d [PHYS_REGS];
    logic [TAG_W:0]   head_q, head_d;
    logic [TAG_W:0]   commit_head_q, commit_head_d;
    logic [TAG_W:0]   tail_q, tail_d;
    logic [TAG_W:0]   free_count_q, free_count_d;
    logic [TAG_W:0]   n_alloc, n_free;
    logic [FETCH_WIDTH-1:0] lane_sel;
    logic             alloc_fire;

    // Ready looks only at registered occupancy; freed tags are not bypassed.
    assign fl.rename_ready = rst_b & ~fl.flush & (free_count_q >= FW_CNT);
    assign fl.free_count   = free_count_q;

    // Allocation side: valid lanes take consecutive entries from head in lane order.
    // With no lane requesting, lanes show the next FETCH_WIDTH free tags.
    always_comb begin
        lane_sel     = (fl.rename_valid == '0) ? '1 : fl.rename_valid;
        alloc_fire   = fl.rename_ready & (|fl.rename_valid);
        fl.alloc_tag = '0;
        n_alloc      = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fl.alloc_tag[i*TAG_W +: TAG_W] = mem_q[TAG_W'(head_q + n_alloc)];
            if (lane_sel[i]) begin
                n_alloc = n_alloc + 1'b1;
            end
        end
        if (!alloc_fire) begin
            n_alloc = '0;
        end
    end

    // Free side: returned stale tags are packed at tail; flush rewinds head
    // to the commit point after this cycle's commits are applied.
    always_comb begin
        mem_d  = mem_q;
        n_free = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (fl.commit_valid[j] && fl.commit_alloc[j]) begin
                mem_d[TAG_W'(tail_q + n_free)] = fl.commit_free_tag[j*TAG_W +: TAG_W];
                n_free = n_free + 1'b1;
            end
        end
        tail_d        = tail_q + n_free;
        commit_head_d = commit_head_q + n_free;
        head_d        = fl.flush ? commit_head_d : (head_q + n_alloc);
        free_count_d  = tail_d - head_d;
    end

    // State registers; reset reloads the non-architectural tags in order.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_q[i] <= TAG_W'(ARCH_REGS + i);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= INIT_FREE;
            free_count_q  <= INIT_FREE;
        end else begin
            mem_q         <= mem_d;
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            free_count_q  <= free_count_d;
        end
    end

`ifdef FREE_LIST_ASSERT_EN
    // Usage and invariant checks sampled on each active edge.
    always_ff @(posedge clk_sys) begin
        if (rst_b) begin
            assert (!((|fl.rename_valid) && !fl.rename_ready))
                else $error("free_list: alloc_while_not_ready");
            assert (free_count_d <= INIT_FREE)
                else $error("free_list: free_count_overflow");
            assert ((fl.commit_alloc & ~fl.commit_valid) == '0)
                else $error("free_list: commit_alloc_without_valid");
            assert ((head_d - commit_head_d) <= (TAG_W+1)'(PHYS_REGS))
                else $error("free_list: commit_head_overtakes_head");
        end
    end
`else
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model
// (avail = free tags in order, pend = allocated but not yet committed)
// with a scoreboard of expected allocation tags.
module tb_free_list;
    localparam int TW = 6;

    logic clk_sys = 1'b0;
    logic rst_b   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   avail[$];
    int   pend[$];
    int   exp_q[$];

    free_list_if #(.FETCH_WIDTH(4), .COMMIT_WIDTH(4), .TAG_W(TW)) fl_if ();

    free_list dut (
        .clk_sys (clk_sys),
        .rst_b   (rst_b),
        .fl      (fl_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        fl_if.rename_valid    = '0;
        fl_if.commit_valid    = '0;
        fl_if.commit_alloc    = '0;
        fl_if.commit_free_tag = '0;
        fl_if.flush           = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_b                 = 1'b0;
        fl_if.rename_valid    = 4'hF;
        fl_if.commit_valid    = 4'hF;
        fl_if.commit_alloc    = 4'hF;
        fl_if.commit_free_tag = 24'h555555;
        fl_if.flush           = 1'b0;
        #1 chk("ready_in_reset", fl_if.rename_ready, 0);
        @(posedge clk_sys);
        #1;
        chk("ready_in_reset_post", fl_if.rename_ready, 0);
        chk("count_after_reset", fl_if.free_count, 32);
        @(negedge clk_sys);
        rst_b = 1'b1;
        drive_idle();
        avail.delete();
        pend.delete();
        exp_q.delete();
        for (int i = 32; i < 64; i++) avail.push_back(i);
    endtask

    task automatic step(input logic [3:0] rv, input logic [3:0] cv, input logic [3:0] ca,
                        input logic [23:0] ctags, input logic fls);
        logic exp_ready;
        int   t;
        @(negedge clk_sys);
        fl_if.rename_valid    = rv;
        fl_if.commit_valid    = cv;
        fl_if.commit_alloc    = ca;
        fl_if.commit_free_tag = ctags;
        fl_if.flush           = fls;
        #1;
        exp_ready = (avail.size() >= 4) && !fls;
        chk("rename_ready", fl_if.rename_ready, int'(exp_ready));
        if (exp_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (rv == 4'b0) begin
                    exp_q.push_back(avail[i]);
                end else if (rv[i]) begin
                    t = avail.pop_front();
                    pend.push_back(t);
                    exp_q.push_back(t);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (rv == 4'b0 || rv[i]) begin
                    chk($sformatf("alloc_tag%0d", i), int'(fl_if.alloc_tag[i*TW +: TW]), exp_q.pop_front());
                end
            end
        end
        @(posedge clk_sys);
        for (int j = 0; j < 4; j++) begin
            if (cv[j] && ca[j]) begin
                if (pend.size() > 0) void'(pend.pop_front());
                avail.push_back(int'(ctags[j*TW +: TW]));
            end
        end
        if (fls) begin
            avail = {pend, avail};
            pend.delete();
        end
        #1 chk("free_count", fl_if.free_count, avail.size());
    endtask

    initial begin
        logic [3:0]  rv, cv, ca;
        logic [23:0] tg;
        logic        fls;
        int          budget;

        drive_idle();
        do_reset();

        // idle peek, then partial group 1011
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);
        step(4'b1011, 4'b0, 4'b0, 24'h0, 1'b0);
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);

        // mid-operation reset, then drain the list completely
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        chk("empty_count", fl_if.free_count, 0);
        step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        // from empty, commit four allocators returning tags 0..3
        step(4'b0000, 4'b1111, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 1'b0);
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);

        // allocate 8, commit 4, then flush
        do_reset();
        step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        step(4'b0000, 4'b1111, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 1'b0);
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b1);
        chk("flush_count", fl_if.free_count, 32);
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);
        // flush together with a commit
        step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        step(4'b0011, 4'b0101, 4'b0101, {6'd0, 6'd9, 6'd0, 6'd8}, 1'b1);
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);

        // full wrap: allocate 32, commit 32 returning 0..31
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tg = {6'(4*k+3), 6'(4*k+2), 6'(4*k+1), 6'(4*k)};
            step(4'b0000, 4'b1111, 4'b1111, tg, 1'b0);
        end
        chk("wrap_count", fl_if.free_count, 32);
        step(4'b1111, 4'b0, 4'b0, 24'h0, 1'b0);

        // random mix bounded so frees never exceed outstanding allocations
        for (int k = 0; k < 80; k++) begin
            rv     = 4'($urandom);
            cv     = 4'($urandom);
            ca     = '0;
            budget = pend.size();
            for (int j = 0; j < 4; j++) begin
                if (cv[j] && budget > 0 && $urandom_range(0, 3) != 0) begin
                    ca[j] = 1'b1;
                    budget--;
                end
            end
            tg  = 24'($urandom);
            fls = ($urandom_range(0, 15) == 0);
            step(rv, cv, ca, tg, fls);
        end
        step(4'b0000, 4'b0, 4'b0, 24'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
